dual_issue_queue: RTL
=====================

# dual_issue_queue

Parametrised issue stage sitting between decode and the two execution pipes. Decoded instructions are buffered in a DEPTH-entry circular queue, two per cycle. Each cycle the block issues the head instruction to pipe A and, when pairing rules allow, the next one to pipe B. It generalises the fixed OR/OR dual-issue decision into a class-mask and hazard-checked pairing policy with buffering, flush, stall, and an issue statistics counter.

## Interface
Parameters:
- DEPTH, 8, queue entries; power of 2, at least 4.
- CLS_W, 3, width of the instruction class code.
- PAIR_EN, 1, 0 forces single issue; 1 enables pairing.
- PAIR_MASK, 8'b0000_0011, bit k set means class k may issue in slot B.

Class codes: 0 ALU, 1 SHIFT, 2 MEM, 3 MULDIV, 4 BRANCH, 5 PRIV; 6 and 7 are treated as PRIV.

Ports (lane i uses bits [i*W +: W]):
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all queued entries and this cycle's enqueue.
- stall  in  1  downstream not accepting; no issue this cycle.
- in_valid  in  2  lane valid bits, lane 0 older.
- in_cls  in  2*CLS_W  class code.
- in_dst, in_srca, in_srcb  in  2*5 each  register numbers.
- in_we  in  2  writes in_dst.
- in_ds  in  2  instruction is in a branch delay slot.
- in_ready  out  1  at least 2 free entries.
- out_valid_a, out_valid_b  out  1 each  issue slot valid.
- out_cls_a/b, out_dst_a/b, out_srca_a/b, out_srcb_a/b, out_we_a/b, out_ds_a/b  out  entry fields per slot.
- count  out  $clog2(DEPTH)+1  occupied entries.
- dual_cnt  out  32  cycles in which two instructions issued.

## Operation
- **Storage**
  - Circular buffer with head and tail pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
  - count is maintained explicitly, so full and empty are unambiguous.
- **Enqueue**
  - Occurs only when in_ready=1 and flush=0.
  - Valid lanes are written in order, lane 0 first, starting at tail. Invalid lanes are skipped, so in_valid=2'b10 writes lane 1 to tail.
  - tail advances by popcount(in_valid).
  - If in_valid is nonzero while in_ready=0, the input is ignored; decode must hold.
- **Slot A:** out_valid_a = (count≥1) & ~stall & ~flush. Slot A carries the entry at head.
- **Slot B:** out_valid_b = out_valid_a & (count≥2) & PAIR_EN & pair_ok. Slot B carries the entry at head+1.
- **pair_ok requires all of:**
  - A.ds = 0;
  - A class is not PRIV;
  - B class is not BRANCH and not PRIV;
  - PAIR_MASK[B.cls] = 1;
  - no RAW hazard: not (A.we & A.dst≠0 & (A.dst==B.srca | A.dst==B.srcb));
  - no WAW hazard: not (A.we & B.we & A.dst==B.dst & A.dst≠0);
  - not (A.cls==B.cls & B.cls ∈ {MEM, MULDIV}).
- **Dequeue:** head advances by out_valid_a + out_valid_b.
- **Occupancy:** count_next = count + enq − deq. Enqueue and dequeue in the same cycle are legal.
- **Statistics:** dual_cnt increments by 1 in every cycle with out_valid_b=1, and wraps from 2^32−1 to 0.
- **Flush**
  - head, tail and count go to 0; the enqueue in that cycle is dropped.
  - out_valid_a and out_valid_b are 0 in that cycle; dual_cnt is not incremented.
  - Flush has priority over enqueue and stall.

## Timing
- **Reset**
  - On the clk edge with rst_n=0: head, tail, count and dual_cnt go to 0.
  - Output fields go to 0, out_valid_a and out_valid_b go to 0, and in_ready goes to 1.
  - Reset overrides flush and in-flight enqueues.
- **Latency:** an instruction enqueued at edge n can issue in the cycle following edge n. There is no same-cycle bypass.
- **Outputs**
  - Output fields are driven combinationally from the queue registers and the head pointer.
  - The out_valid signals depend combinationally on stall and flush.
- **in_ready:** combinational from the registered count, equal to (DEPTH − count ≥ 2). It is therefore 0 when count is DEPTH−1 or DEPTH.
- **Stall:** no entries are consumed and the output fields hold the head entries; enqueue continues while in_ready=1.
- **Wrap-around:** pairing across the wrap boundary (head=DEPTH−1, head+1=0) behaves identically to the non-wrapping case.

## Test plan
- **Pairable burst:** from reset, enqueue pairs ALU/ALU {dst 1, src 2,3}, {dst 4, src 5,6} → issued as a pair one cycle later; count 2→0; dual_cnt=1.
- **Single-issue cases:** each of the following, enqueued behind an ALU in slot A, issues alone with out_valid_b=0, and the second instruction issues next cycle as A:
  - RAW: B reads dst 7 written by A;
  - B is a MEM, because PAIR_MASK[2]=0;
  - A.ds=1.
- **Full queue (DEPTH=8):** fill with stall=1 → in_ready drops at count=7. Offer a pair at count=7 → it is ignored and count stays 7. Release stall → two entries issue per cycle and in_ready returns.
- **Wrap-around:** cycle 20 random pairable/non-pairable instructions through DEPTH=4 → the issue order matches enqueue order exactly, and the final pointers equal 20 mod 4.
- **Flush:** flush with count=5 while enqueuing 2 → next cycle count=0, out_valid_a=0, dual_cnt unchanged.
- **Mid-operation reset:** assert rst_n=0 for one cycle mid-stream → all outputs at reset values; the first post-reset enqueue issues normally.

Source files
------------

// File: rtl/dual_issue_queue.sv
// dual_issue_queue: issue stage between decode and the two execution pipes.
// Decoded instructions are buffered in a DEPTH-entry circular queue (up to two
// enqueued per cycle). Each cycle the head entry issues to pipe A and, when the
// pairing policy allows, the next entry issues to pipe B.
//
// Ports (lane i of a two-lane input uses bits [i*W +: W], lane 0 is older):
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      drop all queued entries and this cycle's enqueue
//   stall                      downstream not accepting, nothing issues
//   in_valid/in_cls/in_dst/
//   in_srca/in_srcb/in_we/in_ds  two decoded instructions from decode
//   in_ready                   at least two free entries
//   out_valid_a/b, out_*_a/b   issue slot A (head) and slot B (head+1)
//   count                      occupied entries
//   dual_cnt                   cycles in which two instructions issued
module dual_issue_queue #(
    parameter int unsigned               DEPTH     = 8,
    parameter int unsigned               CLS_W     = 3,
    parameter bit                        PAIR_EN   = 1'b1,
    parameter logic [(1<<CLS_W)-1:0]     PAIR_MASK = 8'b0000_0011
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   stall,
    input  logic [1:0]             in_valid,
    input  logic [2*CLS_W-1:0]     in_cls,
    input  logic [9:0]             in_dst,
    input  logic [9:0]             in_srca,
    input  logic [9:0]             in_srcb,
    input  logic [1:0]             in_we,
    input  logic [1:0]             in_ds,
    output logic                   in_ready,
    output logic                   out_valid_a,
    output logic                   out_valid_b,
    output logic [CLS_W-1:0]       out_cls_a,
    output logic [CLS_W-1:0]       out_cls_b,
    output logic [4:0]             out_dst_a,
    output logic [4:0]             out_dst_b,
    output logic [4:0]             out_srca_a,
    output logic [4:0]             out_srca_b,
    output logic [4:0]             out_srcb_a,
    output logic [4:0]             out_srcb_b,
    output logic                   out_we_a,
    output logic                   out_we_b,
    output logic                   out_ds_a,
    output logic                   out_ds_b,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            dual_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [CLS_W-1:0] ClsMem    = CLS_W'(2);
    localparam logic [CLS_W-1:0] ClsMulDiv = CLS_W'(3);
    localparam logic [CLS_W-1:0] ClsBranch = CLS_W'(4);
    // Codes at or above this value (5, 6, 7) are all privileged.
    localparam logic [CLS_W-1:0] ClsPriv   = CLS_W'(5);

    typedef struct packed {
        logic [CLS_W-1:0] cls;
        logic [4:0]       dst;
        logic [4:0]       srca;
        logic [4:0]       srcb;
        logic             we;
        logic             ds;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    dual_q, dual_d;

    entry_t         lane [2];
    entry_t         ent_a, ent_b;
    logic           enq_ok, wr0, wr1;
    logic [PW-1:0]  wr1_ptr;
    logic [CW-1:0]  enq_n, deq_n;
    logic           pair_ok;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane[i].cls  = in_cls[i*CLS_W +: CLS_W];
            lane[i].dst  = in_dst[i*5 +: 5];
            lane[i].srca = in_srca[i*5 +: 5];
            lane[i].srcb = in_srcb[i*5 +: 5];
            lane[i].we   = in_we[i];
            lane[i].ds   = in_ds[i];
        end
    end

    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign enq_ok   = in_ready & ~flush;
    assign wr0      = enq_ok & in_valid[0];
    assign wr1      = enq_ok & in_valid[1];
    // Lane 1 lands right after lane 0, or at tail itself when lane 0 is empty.
    assign wr1_ptr  = tail_q + PW'(in_valid[0]);
    assign enq_n    = CW'(wr0) + CW'(wr1);

    assign ent_a = mem_q[head_q];
    assign ent_b = mem_q[head_q + PW'(1)];

    always_comb begin
        pair_ok = 1'b1;
        if (ent_a.ds) pair_ok = 1'b0;
        if (ent_a.cls >= ClsPriv) pair_ok = 1'b0;
        if (ent_b.cls == ClsBranch || ent_b.cls >= ClsPriv) pair_ok = 1'b0;
        if (!PAIR_MASK[ent_b.cls]) pair_ok = 1'b0;
        // RAW: B would read a register A is still producing.
        if (ent_a.we && ent_a.dst != 5'd0 &&
            (ent_a.dst == ent_b.srca || ent_a.dst == ent_b.srcb)) pair_ok = 1'b0;
        // WAW: both write the same architectural register.
        if (ent_a.we && ent_b.we && ent_a.dst == ent_b.dst && ent_a.dst != 5'd0) pair_ok = 1'b0;
        // Only one MEM port and one MULDIV unit.
        if (ent_a.cls == ent_b.cls && (ent_b.cls == ClsMem || ent_b.cls == ClsMulDiv)) begin
            pair_ok = 1'b0;
        end
    end

    assign out_valid_a = (count_q != '0) & ~stall & ~flush;
    assign out_valid_b = out_valid_a & (count_q >= CW'(2)) & PAIR_EN & pair_ok;
    assign deq_n       = CW'(out_valid_a) + CW'(out_valid_b);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dual_d  = dual_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + deq_n[PW-1:0];
            tail_d  = tail_q + enq_n[PW-1:0];
            count_d = count_q + enq_n - deq_n;
            dual_d  = dual_q + 32'(out_valid_b);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dual_q  <= '0;
            // Cleared so the combinational output fields read zero after reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dual_q  <= dual_d;
            if (wr0) mem_q[tail_q]  <= lane[0];
            if (wr1) mem_q[wr1_ptr] <= lane[1];
        end
    end

    assign out_cls_a  = ent_a.cls;
    assign out_dst_a  = ent_a.dst;
    assign out_srca_a = ent_a.srca;
    assign out_srcb_a = ent_a.srcb;
    assign out_we_a   = ent_a.we;
    assign out_ds_a   = ent_a.ds;
    assign out_cls_b  = ent_b.cls;
    assign out_dst_b  = ent_b.dst;
    assign out_srca_b = ent_b.srca;
    assign out_srcb_b = ent_b.srcb;
    assign out_we_b   = ent_b.we;
    assign out_ds_b   = ent_b.ds;
    assign count      = count_q;
    assign dual_cnt   = dual_q;

endmodule
